// File: rtl/pim_result_aggregator_pkg.sv
// Shared types and default geometry for the PIM result aggregator.
package pim_result_aggregator_pkg;

    localparam int WIDTH       = 32;
    localparam int CHUNK_SIZE  = 2;
    localparam int MATRIX_SIZE = 4;
    localparam int TPS         = MATRIX_SIZE / CHUNK_SIZE;
    localparam int NUM_TILES   = TPS * TPS;
    localparam int TILE_IDX_W  = $clog2(NUM_TILES);
    localparam int ROW_IDX_W   = $clog2(MATRIX_SIZE);

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } agg_state_t;

    // First matrix row covered by tile t.
    function automatic int tile_row0(input int t, input int tps, input int cs);
        return (t / tps) * cs;
    endfunction

    // First matrix column covered by tile t.
    function automatic int tile_col0(input int t, input int tps, input int cs);
        return (t % tps) * cs;
    endfunction

endpackage

// File: rtl/pim_row_streamer.sv
// Row streamer: walks row_cnt over the finished matrix and presents one row
// per beat. Handshake: a beat transfers on a cycle where out_valid_o and
// out_ready_i are both high; while out_ready_i is low the beat (row data,
// index, last) is held unchanged. out_valid_o follows active_i directly.
module pim_row_streamer #(
    parameter int WIDTH       = 32,
    parameter int MATRIX_SIZE = 4,
    parameter int ROW_W       = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         active_i,
    input  logic [MATRIX_SIZE*WIDTH-1:0] row_data_i,
    input  logic                         out_ready_i,
    output logic [ROW_W-1:0]             row_idx_o,
    output logic                         out_valid_o,
    output logic [MATRIX_SIZE*WIDTH-1:0] out_row_o,
    output logic                         out_last_o,
    output logic                         done_o
);

    logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
    logic             xfer;
    logic             last_row;

    // Beat presentation and transfer detection.
    always_comb begin
        last_row    = (row_cnt_q == ROW_W'(MATRIX_SIZE - 1));
        out_valid_o = active_i;
        xfer        = active_i && out_ready_i;
        out_last_o  = active_i && last_row;
        out_row_o   = active_i ? row_data_i : '0;
        row_idx_o   = row_cnt_q;
        done_o      = xfer && last_row;
        row_cnt_d   = row_cnt_q;
        if (xfer) begin
            row_cnt_d = last_row ? '0 : row_cnt_q + ROW_W'(1);
        end
    end

    // Row counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_q <= '0;
        end else begin
            row_cnt_q <= row_cnt_d;
        end
    end

endmodule

// File: rtl/pim_result_aggregator.sv
// PIM result aggregator: gathers CHUNK_SIZE x CHUNK_SIZE tiles from NUM_UNITS
// units into a MATRIX_SIZE x MATRIX_SIZE buffer, then streams it out one row
// per beat. Optional feature macro: PIM_AGG_PERF_EN adds perf_cycles.
module pim_result_aggregator #(
    parameter int NUM_UNITS      = 4,
    parameter int WIDTH          = pim_result_aggregator_pkg::WIDTH,
    parameter int CHUNK_SIZE     = pim_result_aggregator_pkg::CHUNK_SIZE,
    parameter int MATRIX_SIZE    = pim_result_aggregator_pkg::MATRIX_SIZE,
    localparam int TILES_PER_SIDE = MATRIX_SIZE / CHUNK_SIZE,
    localparam int N_TILES        = TILES_PER_SIDE * TILES_PER_SIDE,
    localparam int TILE_W         = $clog2(N_TILES),
    localparam int ROW_W          = $clog2(MATRIX_SIZE),
    localparam int ELEMS          = CHUNK_SIZE * CHUNK_SIZE
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_UNITS-1:0]              in_valid,
    input  logic [NUM_UNITS*TILE_W-1:0]       in_tile,
    input  logic [NUM_UNITS*ELEMS*WIDTH-1:0]  in_result,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [MATRIX_SIZE*WIDTH-1:0]      out_row,
    output logic [ROW_W-1:0]                  out_row_idx,
    output logic                              out_last,
    output logic                              busy,
    output logic                              err_dup,
    output logic                              err_overrun
`ifdef PIM_AGG_PERF_EN
    ,output logic [31:0]                      perf_cycles
`endif
);

    import pim_result_aggregator_pkg::*;

    agg_state_t                  state_q, state_d;
    logic [N_TILES-1:0]          seen_q, seen_d;
    logic                        err_dup_q, err_dup_d;
    logic                        err_ovr_q, err_ovr_d;
    logic [NUM_UNITS-1:0]        wr_en;
    logic [TILE_W-1:0]           tile_u;
    logic                        drain_done;
    logic [ROW_W-1:0]            row_idx;
    logic [MATRIX_SIZE*WIDTH-1:0] row_data;

    // Buffer contents are never reset; every element is written before a drain.
    logic [WIDTH-1:0] buf_q [MATRIX_SIZE][MATRIX_SIZE];

    // Tile acceptance, duplicate/overrun detection and COLLECT/DRAIN sequencing.
    always_comb begin
        state_d   = state_q;
        seen_d    = seen_q;
        err_dup_d = err_dup_q;
        err_ovr_d = err_ovr_q;
        wr_en     = '0;
        tile_u    = '0;
        case (state_q)
            COLLECT: begin
                // Units are scanned low to high so a repeat within the same
                // cycle sees the bit set by the lower unit.
                for (int u = 0; u < NUM_UNITS; u++) begin
                    if (in_valid[u]) begin
                        tile_u = in_tile[u*TILE_W +: TILE_W];
                        if (int'(tile_u) < N_TILES) begin
                            wr_en[u] = 1'b1;
                            if (seen_d[tile_u]) begin
                                err_dup_d = 1'b1;
                            end
                            seen_d[tile_u] = 1'b1;
                        end else begin
                            err_dup_d = 1'b1;
                        end
                    end
                end
                // The completing tile is written on this edge and the drain
                // begins on the same edge, so the first beat follows 1 cycle later.
                if (&seen_d) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Units cannot be stalled, so anything arriving now is dropped.
                if (|in_valid) begin
                    err_ovr_d = 1'b1;
                end
                if (drain_done) begin
                    seen_d  = '0;
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            seen_q    <= '0;
            err_dup_q <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seen_q    <= seen_d;
            err_dup_q <= err_dup_d;
            err_ovr_q <= err_ovr_d;
        end
    end

    // Tile writes into the buffer; the highest unit index wins on a collision.
    always_ff @(posedge clk) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (wr_en[u]) begin
                for (int i = 0; i < CHUNK_SIZE; i++) begin
                    for (int j = 0; j < CHUNK_SIZE; j++) begin
                        buf_q[tile_row0(int'(in_tile[u*TILE_W +: TILE_W]), TILES_PER_SIDE, CHUNK_SIZE) + i]
                             [tile_col0(int'(in_tile[u*TILE_W +: TILE_W]), TILES_PER_SIDE, CHUNK_SIZE) + j]
                            <= in_result[(u*ELEMS + i*CHUNK_SIZE + j)*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    // Row read port feeding the streamer.
    always_comb begin
        row_data = '0;
        for (int c = 0; c < MATRIX_SIZE; c++) begin
            row_data[c*WIDTH +: WIDTH] = buf_q[row_idx][c];
        end
    end

    pim_row_streamer #(
        .WIDTH       (WIDTH),
        .MATRIX_SIZE (MATRIX_SIZE),
        .ROW_W       (ROW_W)
    ) u_streamer (
        .clk         (clk),
        .rst_n       (rst_n),
        .active_i    (state_q == DRAIN),
        .row_data_i  (row_data),
        .out_ready_i (out_ready),
        .row_idx_o   (row_idx),
        .out_valid_o (out_valid),
        .out_row_o   (out_row),
        .out_last_o  (out_last),
        .done_o      (drain_done)
    );

    assign out_row_idx = row_idx;
    assign busy        = (state_q == DRAIN) || (|seen_q);
    assign err_dup     = err_dup_q;
    assign err_overrun = err_ovr_q;

`ifdef PIM_AGG_PERF_EN
    logic        perf_run_q;
    logic [31:0] perf_cnt_q;
    logic [31:0] perf_q;
    logic        first_accept;
    logic [31:0] perf_cnt_inc;

    assign first_accept = (state_q == COLLECT) && (|wr_en) && !perf_run_q;
    assign perf_cnt_inc = (perf_cnt_q == 32'hFFFF_FFFF) ? perf_cnt_q : perf_cnt_q + 32'd1;

    // Pass cycle counter: counts the first-accept cycle through the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_run_q <= 1'b0;
            perf_cnt_q <= '0;
            perf_q     <= '0;
        end else begin
            if (first_accept) begin
                perf_run_q <= 1'b1;
                perf_cnt_q <= 32'd1;
            end else if (perf_run_q) begin
                perf_cnt_q <= perf_cnt_inc;
            end
            if (drain_done) begin
                perf_run_q <= 1'b0;
                perf_q     <= perf_cnt_inc;
            end
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_pim_result_aggregator.sv
// Directed bench for pim_result_aggregator (default 4x4 matrix, 2x2 tiles).
module tb_pim_result_aggregator;

  localparam int NU = 4;
  localparam int W  = 32;
  localparam int CS = 2;
  localparam int MS = 4;
  localparam int EL = CS * CS;
  localparam int TW = 2;
  localparam int RW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NU-1:0]      in_valid;
  logic [NU*TW-1:0]   in_tile;
  logic [NU*EL*W-1:0] in_result;
  logic               out_valid;
  logic               out_ready;
  logic [MS*W-1:0]    out_row;
  logic [RW-1:0]      out_row_idx;
  logic               out_last;
  logic               busy;
  logic               err_dup;
  logic               err_overrun;
`ifdef PIM_AGG_PERF_EN
  logic [31:0]        perf_cycles;
`endif

  pim_result_aggregator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_tile     (in_tile),
    .in_result   (in_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .out_last    (out_last),
    .busy        (busy),
    .err_dup     (err_dup),
    .err_overrun (err_overrun)
`ifdef PIM_AGG_PERF_EN
    ,.perf_cycles (perf_cycles)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [MS*W-1:0] exp_q[$];
  logic [W-1:0] mat [MS][MS];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] elem(input int tile, input int e, input int salt);
    return W'(salt * 1000 + 100 * tile + e);
  endfunction

  function automatic logic [MS*W-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
    return {W'(c3), W'(c2), W'(c1), W'(c0)};
  endfunction

  // Expected placement: tile t -> rows (t/2)*2+i, cols (t%2)*2+j.
  task automatic place(input int tile, input int salt);
    for (int i = 0; i < CS; i++)
      for (int j = 0; j < CS; j++)
        mat[(tile / 2) * CS + i][(tile % 2) * CS + j] = elem(tile, i * CS + j, salt);
  endtask

  function automatic logic [MS*W-1:0] model_row(input int r);
    logic [MS*W-1:0] v;
    for (int c = 0; c < MS; c++) v[c*W +: W] = mat[r][c];
    return v;
  endfunction

  task automatic push_model();
    for (int r = 0; r < MS; r++) exp_q.push_back(model_row(r));
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid  = '0;
    in_tile   = '0;
    in_result = '0;
  endtask

  task automatic drive(input int u, input int tile, input int salt);
    in_valid[u] = 1'b1;
    in_tile[u*TW +: TW] = tile[TW-1:0];
    for (int e = 0; e < EL; e++) in_result[(u*EL + e)*W +: W] = elem(tile, e, salt);
  endtask

  // Drain one matrix; bp selects the ready pattern 1,0,0,1 (repeating).
  task automatic drain(input bit bp);
    int beat;
    int cyc;
    logic [3:0] pat;
    logic [MS*W-1:0] exp_row;
    beat = 0;
    cyc = 0;
    pat = 4'b1001;
    while (beat < MS && cyc < 40) begin
      exp_row = (exp_q.size() > 0) ? exp_q[0] : '0;
      check("row_valid", out_valid, 1'b1);
      check("row_data", out_row, exp_row);
      check("row_idx", out_row_idx, beat);
      check("row_last", out_last, (beat == MS - 1));
      out_ready = bp ? pat[cyc % 4] : 1'b1;
      if (out_valid && out_ready) begin
        void'(exp_q.pop_front());
        beat++;
      end
      step();
      cyc++;
    end
    out_ready = 1'b0;
    check("beat_count", beat, MS);
    check("valid_drop", out_valid, 1'b0);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    out_ready = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dup", err_dup, 1'b0);
    check("rst_ovr", err_overrun, 1'b0);
    check("rst_row", out_row, '0);
    check("rst_idx", out_row_idx, 0);
`ifdef PIM_AGG_PERF_EN
    check("rst_perf", perf_cycles, 0);
`endif
    rst_n = 1'b1;
    step();

    // Test 1: ordered single arrival, hand-computed rows.
    for (int t = 0; t < 4; t++) begin
      clear_in();
      drive(t, t, 0);
      step();
      if (t == 2) begin
        check("t1_not_yet", out_valid, 1'b0);
        check("t1_busy", busy, 1'b1);
      end
    end
    clear_in();
    check("t1_latency", out_valid, 1'b1);
    exp_q.push_back(pack4(0, 1, 100, 101));
    exp_q.push_back(pack4(2, 3, 102, 103));
    exp_q.push_back(pack4(200, 201, 300, 301));
    exp_q.push_back(pack4(202, 203, 302, 303));
    drain(1'b0);

    // Test 2: all units at once, tiles in reverse order.
    for (int u = 0; u < NU; u++) begin
      drive(u, 3 - u, 1);
      place(3 - u, 1);
    end
    step();
    clear_in();
    check("t2_latency", out_valid, 1'b1);
    push_model();
    drain(1'b0);

    // Test 3: mixed arrival then backpressured drain.
    drive(1, 2, 2); place(2, 2);
    drive(3, 0, 2); place(0, 2);
    step();
    clear_in();
    drive(0, 3, 2); place(3, 2);
    drive(2, 1, 2); place(1, 2);
    step();
    clear_in();
    push_model();
    drain(1'b1);

    // Test 4: tile 1 sent twice, second write wins.
    check("t4_dup_clear", err_dup, 1'b0);
    drive(0, 0, 3); place(0, 3); step(); clear_in();
    drive(1, 1, 3); place(1, 3); step(); clear_in();
    drive(2, 1, 4); place(1, 4); step(); clear_in();
    check("t4_dup_set", err_dup, 1'b1);
    check("t4_wait", out_valid, 1'b0);
    drive(3, 2, 3); place(2, 3); step(); clear_in();
    check("t4_wait2", out_valid, 1'b0);
    drive(0, 3, 3); place(3, 3); step(); clear_in();
    check("t4_start", out_valid, 1'b1);
    push_model();
    drain(1'b0);
    check("t4_dup_sticky", err_dup, 1'b1);
    check("t4_ovr_clear", err_overrun, 1'b0);

    // Test 5: overrun during drain, then reset mid-drain.
    for (int u = 0; u < NU; u++) begin
      drive(u, u, 5);
      place(u, 5);
    end
    step();
    clear_in();
    check("t5_row0", out_row, model_row(0));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    drive(0, 0, 9);
    step();
    clear_in();
    check("t5_ovr", err_overrun, 1'b1);
    check("t5_row1_kept", out_row, model_row(1));
    check("t5_idx1", out_row_idx, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_ovr", err_overrun, 1'b0);
    check("t5_rst_dup", err_dup, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    // Following pass: two units carry tile 0 in one cycle, unit 3 wins.
    drive(0, 0, 7);
    drive(1, 1, 7); place(1, 7);
    drive(2, 2, 7); place(2, 7);
    drive(3, 0, 8); place(0, 8);
    step();
    clear_in();
    check("t5_samecyc_dup", err_dup, 1'b1);
    check("t5_wait", out_valid, 1'b0);
    check("t5_busy", busy, 1'b1);
    drive(1, 3, 7); place(3, 7);
    step();
    clear_in();
    check("t5_start", out_valid, 1'b1);
    push_model();
    drain(1'b0);

`ifdef PIM_AGG_PERF_EN
    // Test 6: 4 arrival cycles + 4 drain beats.
    for (int t = 0; t < 4; t++) begin
      clear_in();
      drive(t, t, 6);
      place(t, 6);
      step();
    end
    clear_in();
    push_model();
    drain(1'b0);
    check("t6_perf", perf_cycles, 8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pim_result_aggregator.md
Name: pim_result_aggregator

Overview:
- Receive end of the PIM unit result interface: collects CHUNK_SIZE x CHUNK_SIZE result tiles from NUM_UNITS PIM units.
- Places each tile into a full MATRIX_SIZE x MATRIX_SIZE result buffer.
- Once every tile has arrived, streams the finished matrix out one row per beat on a valid/ready interface toward the host or writeback.
- Sits between the PIM unit array and the top-level output path.

Parameters:
- NUM_UNITS, 4: number of PIM unit result ports.
- WIDTH, types::WIDTH (32): element width.
- CHUNK_SIZE, types::CHUNK_SIZE (2): tile edge length.
- MATRIX_SIZE, types::MATRIX_SIZE (4): full matrix edge length; must be a multiple of CHUNK_SIZE.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  NUM_UNITS  per-unit result_valid; one-cycle pulse per tile.
- in_tile  in  NUM_UNITS x TILE_IDX_W  tile index carried with each result.
- in_result  in  NUM_UNITS x CHUNK_SIZE**2 x WIDTH  flattened tile; element idx = i*CHUNK_SIZE+j.
- out_valid  out  1  row beat valid.
- out_ready  in  1  downstream accepts beat.
- out_row  out  MATRIX_SIZE x WIDTH  one full result row.
- out_row_idx  out  ROW_IDX_W  row number of current beat.
- out_last  out  1  high with final row beat.
- busy  out  1  high in COLLECT (after first tile) or DRAIN.
- err_dup  out  1  sticky: tile received twice in one pass.
- err_overrun  out  1  sticky: in_valid while in DRAIN.

Behaviour:
- Reset, asynchronous, active-low; all outputs 0, state COLLECT, tile_seen all 0, row counter 0. Buffer contents are not reset and are don't-care until written.
- Tile placement:
  - TPS = MATRIX_SIZE/CHUNK_SIZE; NUM_TILES = TPS*TPS.
  - Tile t covers rows (t/TPS)*CHUNK_SIZE+i and cols (t%TPS)*CHUNK_SIZE+j.
- COLLECT:
  - Every unit with in_valid high is written into the buffer in the same cycle; all units may be valid simultaneously.
  - The unit's tile_seen bit is set.
  - If the tile_seen bit was already set, or two units present the same tile in one cycle, set err_dup; the highest unit index wins the write.
  - in_tile >= NUM_TILES: write dropped, err_dup set.
- COLLECT -> DRAIN the cycle after tile_seen becomes all-ones. No input write is lost: the last tile is written, then the transition occurs.
- DRAIN:
  - out_valid=1, out_row = buffer row[row_cnt], out_row_idx=row_cnt, out_last=(row_cnt==MATRIX_SIZE-1).
  - Beat transfers when out_valid&&out_ready; row_cnt increments.
  - Output holds stable while out_ready=0.
  - On the last transfer: row_cnt->0, tile_seen cleared, out_valid drops next cycle, state -> COLLECT.
- Overrun: PIM units have no backpressure, so in_valid during DRAIN is ignored (buffer unchanged) and err_overrun is set.
- Latency: the first row beat is presented 1 cycle after the final tile's in_valid cycle.
- Error flags clear only on reset.
- Reset mid-pass or mid-drain: all progress discarded; returns to COLLECT with out_valid=0.
- Arithmetic: no data transformation; elements copied bit-exact at WIDTH.

Optional Feature:
- PIM_AGG_PERF_EN defined:
  - Adds output perf_cycles [31:0], cycles from the first tile accepted in a pass to the last row transferred, inclusive.
  - Latched at out_last transfer; counter saturates at 32'hFFFF_FFFF; perf_cycles resets to 0.
- Undefined: port and counter absent; no other behavioural difference.

Decomposition:
- Package types: WIDTH, CHUNK_SIZE, MATRIX_SIZE, TPS, NUM_TILES, TILE_IDX_W=$clog2(NUM_TILES), ROW_IDX_W=$clog2(MATRIX_SIZE), agg_state_t enum {COLLECT, DRAIN}.
- One natural sub-module: pim_row_streamer, which owns row_cnt, the valid/ready handshake and out_last, and is handed buffer rows.

Test Plan:
1. Ordered single arrival: MATRIX_SIZE=4, CHUNK_SIZE=2; units 0..3 pulse once each in consecutive cycles with tiles 0..3, element value = 100*tile+idx -> out_row0 = {0,1,100,101}, row3 = {202,203,302,303}; out_last on row 3; first out_valid 1 cycle after the tile-3 pulse.
2. Simultaneous arrival, reverse IDs: all 4 units valid in one cycle with tiles 3,2,1,0 -> correct placement; out_valid the next cycle; 4 beats with out_ready=1.
3. Backpressure: out_ready toggles 1,0,0,1 during drain -> out_row and out_row_idx stable while stalled; exactly 4 transfers; returns to COLLECT.
4. Duplicate tile: tile 1 sent twice before tile 3 -> err_dup=1 and stays set; the second write wins; drain starts only after tile 3.
5. Overrun plus reset: in_valid on tile 0 during drain row 1 -> err_overrun=1, drained row 0 data unchanged; assert rst_n low mid-drain -> out_valid=0, flags 0; a following full pass drains correctly.
6. PIM_AGG_PERF_EN: tiles arrive at cycles 10..13, drain with out_ready=1 -> perf_cycles=8.
